// File: rtl/ro_puf_eval.sv
// Ring-oscillator PUF evaluation controller: settle, count selected RO edges per group, compare.
// Optional feature: define PUF_MAJORITY_VOTE_EN for VOTES measure/compare passes per request.
module ro_puf_eval #(
  parameter int GROUPS       = 4,
  parameter int RO_PER_GROUP = 16,
  parameter int CHA_W        = 4,
  parameter int CNT_W        = 16,
  parameter int SETTLE_CYC   = 16,
  parameter int WINDOW       = 1024,
  parameter int VOTES        = 3
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [CHA_W-1:0]               cha0,
  input  logic [CHA_W-1:0]               cha1,
  input  logic [GROUPS*RO_PER_GROUP-1:0] ro_in,
  output logic                           ro_enable,
  output logic                           busy,
  output logic                           done,
  output logic [GROUPS-1:0]              response,
  output logic [GROUPS-1:0]              tie
);
  localparam int NRO     = GROUPS * RO_PER_GROUP;
  localparam int TMR_MAX = (SETTLE_CYC > WINDOW) ? SETTLE_CYC : WINDOW;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;

  if (VOTES < 1 || (VOTES % 2) == 0) begin : g_votes_chk
    $error("VOTES must be odd and at least 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_MEASURE, S_COMPARE, S_DONE} state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [CHA_W-1:0] cha0_q, cha1_q;
  logic             cnt_clr, cnt_en;
  logic [GROUPS-1:0] edge_a, edge_b, gt, eq;

  // Two-flop synchroniser plus registered rising-edge detect on every RO input.
  logic [NRO-1:0] ro_s1, ro_s2, ro_s3, ro_edge;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ro_s1   <= '0;
      ro_s2   <= '0;
      ro_s3   <= '0;
      ro_edge <= '0;
    end else begin
      ro_s1   <= ro_in;
      ro_s2   <= ro_s1;
      ro_s3   <= ro_s2;
      ro_edge <= ro_s2 & ~ro_s3;
    end
  end

  assign cnt_clr = ((state == S_IDLE) && start) || (state == S_COMPARE);
  assign cnt_en  = (state == S_MEASURE);

  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    logic [RO_PER_GROUP-1:0] grp_edge;
    logic [CNT_W-1:0]        cnt_a, cnt_b;

    assign grp_edge  = ro_edge[g*RO_PER_GROUP +: RO_PER_GROUP];
    assign edge_a[g] = grp_edge[cha0_q];
    assign edge_b[g] = grp_edge[cha1_q];

    // Saturating counters: a fast oscillator pins at all-ones rather than wrapping past a slow one.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_a <= '0;
        cnt_b <= '0;
      end else if (cnt_clr) begin
        cnt_a <= '0;
        cnt_b <= '0;
      end else if (cnt_en) begin
        if (edge_a[g] && (cnt_a != '1)) cnt_a <= cnt_a + 1'b1;
        if (edge_b[g] && (cnt_b != '1)) cnt_b <= cnt_b + 1'b1;
      end
    end

    assign gt[g] = (cnt_a > cnt_b);
    assign eq[g] = (cnt_a == cnt_b);
  end

`ifdef PUF_MAJORITY_VOTE_EN
  localparam int VW = $clog2(VOTES + 1);
  localparam int PW = $clog2(VOTES) + 1;

  logic [VW-1:0]     vote_cnt [GROUPS];
  logic [PW-1:0]     pass;
  logic [GROUPS-1:0] all_eq, vote_win;

  // Final-pass tally includes the gt result being computed in this COMPARE cycle.
  always_comb begin
    // NOTE: default assignment first so the combinational block can never infer a latch.
    vote_win = '0;
    for (int g = 0; g < GROUPS; g++)
      vote_win[g] = ({1'b0, vote_cnt[g]} + {{VW{1'b0}}, gt[g]}) > (VW+1)'(VOTES / 2);
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      timer     <= '0;
      cha0_q    <= '0;
      cha1_q    <= '0;
      busy      <= 1'b0;
      ro_enable <= 1'b0;
      done      <= 1'b0;
      response  <= '0;
      tie       <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
      pass      <= '0;
      all_eq    <= '0;
      for (int g = 0; g < GROUPS; g++) vote_cnt[g] <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          cha0_q    <= cha0;
          cha1_q    <= cha1;
          timer     <= '0;
          busy      <= 1'b1;
          ro_enable <= 1'b1;
          state     <= S_SETTLE;
`ifdef PUF_MAJORITY_VOTE_EN
          pass      <= '0;
          all_eq    <= '1;
          for (int g = 0; g < GROUPS; g++) vote_cnt[g] <= '0;
`endif
        end
        S_SETTLE: begin
          if (timer == TMR_W'(SETTLE_CYC - 1)) begin
            timer <= '0;
            state <= S_MEASURE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_MEASURE: begin
          if (timer == TMR_W'(WINDOW - 1)) begin
            timer <= '0;
            state <= S_COMPARE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_COMPARE: begin
`ifdef PUF_MAJORITY_VOTE_EN
          for (int g = 0; g < GROUPS; g++) vote_cnt[g] <= vote_cnt[g] + VW'(gt[g]);
          all_eq <= all_eq & eq;
          if (pass == PW'(VOTES - 1)) begin
            response <= vote_win;
            tie      <= all_eq & eq;
            done     <= 1'b1;
            state    <= S_DONE;
          end else begin
            pass  <= pass + 1'b1;
            state <= S_MEASURE;
          end
`else
          response <= gt;
          tie      <= eq;
          done     <= 1'b1;
          state    <= S_DONE;
`endif
        end
        S_DONE: begin
          busy      <= 1'b0;
          ro_enable <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_puf_eval.sv
// Scoreboard bench for ro_puf_eval: directed RO periods, expected results queued at start, monitors check on done.
`timescale 1ns/1ps
module tb_ro_puf_eval;
  localparam int GROUPS  = 4;
  localparam int RPG     = 16;
  localparam int CHA_W   = 4;
  localparam int SETTLE  = 4;
  localparam int WIN     = 64;
  localparam int WIN_SAT = 200;
  localparam int VOTES   = 3;
  localparam int NRO     = GROUPS * RPG;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int LAT     = SETTLE + VOTES * (WIN + 1) + 1;
  localparam int LAT_SAT = SETTLE + VOTES * (WIN_SAT + 1) + 1;
`else
  localparam int LAT     = SETTLE + WIN + 2;
  localparam int LAT_SAT = SETTLE + WIN_SAT + 2;
`endif

  typedef struct {
    logic [GROUPS-1:0] resp;
    logic [GROUPS-1:0] tie;
    int unsigned       cyc;
    string             name;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0, start_sat = 1'b0;
  logic [CHA_W-1:0]  cha0 = '0, cha1 = '0;
  logic [NRO-1:0]    ro_in = '0;
  logic              ro_enable, busy, done;
  logic [GROUPS-1:0] response, tie;
  logic              ro_enable_s, busy_s, done_s;
  logic [GROUPS-1:0] response_s, tie_s;

  exp_t        q_main[$], q_sat[$];
  int          n_cmp = 0, n_fail = 0;
  int          n_done_main = 0, n_done_sat = 0;
  int unsigned edge_cnt = 0;
  int          per[NRO];
  int          ph[NRO];

  ro_puf_eval #(.GROUPS(GROUPS), .RO_PER_GROUP(RPG), .CHA_W(CHA_W), .CNT_W(16),
                .SETTLE_CYC(SETTLE), .WINDOW(WIN), .VOTES(VOTES)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cha0(cha0), .cha1(cha1), .ro_in(ro_in),
    .ro_enable(ro_enable), .busy(busy), .done(done), .response(response), .tie(tie));

  ro_puf_eval #(.GROUPS(GROUPS), .RO_PER_GROUP(RPG), .CHA_W(CHA_W), .CNT_W(4),
                .SETTLE_CYC(SETTLE), .WINDOW(WIN_SAT), .VOTES(VOTES)) dut_sat (
    .clk(clk), .reset_n(reset_n), .start(start_sat), .cha0(cha0), .cha1(cha1), .ro_in(ro_in),
    .ro_enable(ro_enable_s), .busy(busy_s), .done(done_s), .response(response_s), .tie(tie_s));

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // RO model: square wave of per[b] clk cycles, updated on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int b = 0; b < NRO; b++) begin
        if (per[b] == 0) ro_in[b] = 1'b0;
        else begin
          ph[b]    = (ph[b] + 1) % per[b];
          ro_in[b] = (ph[b] < per[b] / 2);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Periods for RO index a and b; grp_swap selects groups where the two are exchanged.
  task automatic set_periods(input int ia, input int pa, input int ib, input int pb,
                             input logic [GROUPS-1:0] grp_swap);
    for (int g = 0; g < GROUPS; g++)
      for (int i = 0; i < RPG; i++) begin
        if (i == ia)      per[g*RPG+i] = grp_swap[g] ? pb : pa;
        else if (i == ib) per[g*RPG+i] = grp_swap[g] ? pa : pb;
        else              per[g*RPG+i] = 12;
      end
  endtask

  task automatic launch(input bit use_sat, input logic [CHA_W-1:0] c0, input logic [CHA_W-1:0] c1,
                        input logic [GROUPS-1:0] er, input logic [GROUPS-1:0] et,
                        input bit expect_done, input string nm, output int unsigned k);
    exp_t e;
    @(negedge clk);
    cha0 = c0;
    cha1 = c1;
    if (use_sat) start_sat = 1'b1; else start = 1'b1;
    k      = edge_cnt + 1;
    e.resp = er;
    e.tie  = et;
    e.cyc  = k + (use_sat ? LAT_SAT : LAT);
    e.name = nm;
    if (expect_done) begin
      if (use_sat) q_sat.push_back(e); else q_main.push_back(e);
    end
    @(negedge clk);
    start     = 1'b0;
    start_sat = 1'b0;
  endtask

  task automatic wait_done(input bit use_sat, input int target, input string nm);
    int budget = 3000;
    while (((use_sat ? n_done_sat : n_done_main) < target) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({nm, " done count"}, use_sat ? n_done_sat : n_done_main, target);
  endtask

  initial begin : mon_main
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        n_done_main++;
        check("main done expected", q_main.size(), 1);
        if (q_main.size() > 0) begin
          e = q_main.pop_front();
          check({e.name, " response"}, response, e.resp);
          check({e.name, " tie"}, tie, e.tie);
          check({e.name, " done cycle"}, edge_cnt + 1, e.cyc);
        end
      end
    end
  end

  initial begin : mon_sat
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_s) begin
        n_done_sat++;
        check("sat done expected", q_sat.size(), 1);
        if (q_sat.size() > 0) begin
          e = q_sat.pop_front();
          check({e.name, " response"}, response_s, e.resp);
          check({e.name, " tie"}, tie_s, e.tie);
          check({e.name, " done cycle"}, edge_cnt + 1, e.cyc);
        end
      end
    end
  end

  initial begin : stim
    int unsigned k;
    int          nd;

    set_periods(2, 4, 5, 8, 4'b1010);
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset ro_enable", ro_enable, 0);
    check("reset done", done, 0);
    check("reset response", response, 0);
    check("reset tie", tie, 0);
    reset_n = 1'b1;

    // Groups 0,2: A period 4, B period 8; groups 1,3 swapped.
    launch(0, 4'd2, 4'd5, 4'b0101, 4'b0000, 1, "basic", k);
    wait_done(0, 1, "basic");

    launch(0, 4'd7, 4'd7, 4'b0000, 4'b1111, 1, "same_cha", k);
    wait_done(0, 2, "same_cha");

    // Mid-run challenge change and start re-pulse must both be ignored.
    launch(0, 4'd2, 4'd5, 4'b0101, 4'b0000, 1, "restart", k);
    while (edge_cnt < k + SETTLE + 10) @(negedge clk);
    cha0  = 4'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(0, 3, "restart");
    repeat (LAT + 10) @(negedge clk);
    check("restart single done", n_done_main, 3);

    // Reset mid-MEASURE: outputs clear at once and no done follows.
    launch(0, 4'd2, 4'd5, 4'b0101, 4'b0000, 0, "abort", k);
    while (edge_cnt < k + SETTLE + 20) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort ro_enable", ro_enable, 0);
    check("abort response", response, 0);
    check("abort tie", tie, 0);
    nd = n_done_main;
    repeat (LAT + 10) @(negedge clk);
    check("abort no done", n_done_main, nd);
    reset_n = 1'b1;
    launch(0, 4'd2, 4'd5, 4'b0101, 4'b0000, 1, "post_reset", k);
    wait_done(0, 4, "post_reset");

    // 4-bit counters: both paths exceed 15 edges in 200 cycles and saturate.
    set_periods(2, 4, 5, 6, 4'b0000);
    launch(1, 4'd2, 4'd5, 4'b0000, 4'b1111, 1, "saturate", k);
    wait_done(1, 1, "saturate");

`ifdef PUF_MAJORITY_VOTE_EN
    // A faster in passes 1 and 3, slower in pass 2.
    set_periods(2, 4, 5, 8, 4'b0000);
    launch(0, 4'd2, 4'd5, 4'b1111, 4'b0000, 1, "vote", k);
    while (edge_cnt < k + SETTLE + WIN + 1) @(negedge clk);
    set_periods(2, 8, 5, 4, 4'b0000);
    while (edge_cnt < k + SETTLE + 2 * (WIN + 1)) @(negedge clk);
    set_periods(2, 4, 5, 8, 4'b0000);
    wait_done(0, 5, "vote");
`endif

    repeat (5) @(negedge clk);
    check("main queue drained", q_main.size(), 0);
    check("sat queue drained", q_sat.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
